// File: rtl/lioncage_gate_seq.sv
// Direction-decoding sequencer for the lion cage gate: synchronises and debounces
// both light barriers, tracks the four-phase pass and drives the lion counter.
module lioncage_gate_seq #(
    parameter int unsigned DEBOUNCE_CYCLES = 4,
    parameter int unsigned CAPACITY        = 15,
    parameter int unsigned TIMEOUT_CYCLES  = 200
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       g_one,
    input  logic       g_two,
    input  logic [3:0] count,
    input  logic       clear_err,
    output logic       inc_pulse,
    output logic       dec_pulse,
    output logic       door_lock,
    output logic [1:0] err_code,
    output logic       err_pulse,
    output logic [2:0] state_dbg
);

    localparam int unsigned DB_W  = 4;
    localparam int unsigned TMO_W = 8;
    localparam int unsigned CNT_W = 4;

    localparam logic [DB_W-1:0]  DB_LAST  = DB_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(TIMEOUT_CYCLES - 1);
    localparam logic [CNT_W-1:0] CAP      = CNT_W'(CAPACITY);

    localparam logic [1:0] ERR_NONE  = 2'd0;
    localparam logic [1:0] ERR_SEQ   = 2'd1;
    localparam logic [1:0] ERR_TMO   = 2'd2;
    localparam logic [1:0] ERR_BOUND = 2'd3;

    typedef enum logic [2:0] {
        IDLE = 3'd0,
        EN1  = 3'd1,
        EN2  = 3'd2,
        EN3  = 3'd3,
        EX1  = 3'd4,
        EX2  = 3'd5,
        EX3  = 3'd6,
        ERR  = 3'd7
    } state_t;

    state_t state;

    // Index 1 is the outer barrier (g_one), index 0 the inner barrier (g_two).
    logic [1:0]      raw;
    logic [1:0]      sync1;
    logic [1:0]      sync2;
    logic [1:0]      b;
    logic [DB_W-1:0] db_cnt [2];

    assign raw = {g_one, g_two};

    // Two-flop synchroniser followed by a per-barrier stability counter.
    always_ff @(posedge clk) begin
        if (reset) begin
            sync1     <= '0;
            sync2     <= '0;
            b         <= '0;
            db_cnt[0] <= '0;
            db_cnt[1] <= '0;
        end else begin
            sync1 <= raw;
            sync2 <= sync1;
            for (int i = 0; i < 2; i++) begin
                if (sync2[i] != b[i]) begin
                    if (db_cnt[i] == DB_LAST) begin
                        b[i]      <= sync2[i];
                        db_cnt[i] <= '0;
                    end else begin
                        db_cnt[i] <= db_cnt[i] + 1'b1;
                    end
                end else begin
                    db_cnt[i] <= '0;
                end
            end
        end
    end

    logic [TMO_W-1:0] tmo_cnt;
    logic             in_pass;
    logic             tmo_hit;
    state_t           step_state;
    logic             step_bad;
    logic             entry_done;
    logic             exit_done;

    assign in_pass = (state != IDLE) && (state != ERR);
    assign tmo_hit = in_pass && (tmo_cnt == TMO_LAST);

    // Pass-sequence transition table; anything not listed is a sequence error.
    always_comb begin
        step_state = state;
        step_bad   = 1'b0;
        entry_done = 1'b0;
        exit_done  = 1'b0;
        unique case (state)
            IDLE: begin
                unique case (b)
                    2'b00:   step_state = IDLE;
                    2'b10:   step_state = EN1;
                    2'b01:   step_state = EX1;
                    default: step_bad   = 1'b1;
                endcase
            end
            EN1: begin
                unique case (b)
                    2'b10:   step_state = EN1;
                    2'b11:   step_state = EN2;
                    2'b00:   step_state = IDLE;
                    default: step_bad   = 1'b1;
                endcase
            end
            EN2: begin
                unique case (b)
                    2'b11:   step_state = EN2;
                    2'b01:   step_state = EN3;
                    2'b10:   step_state = EN1;
                    default: step_bad   = 1'b1;
                endcase
            end
            EN3: begin
                unique case (b)
                    2'b01:   step_state = EN3;
                    2'b11:   step_state = EN2;
                    2'b00: begin
                        step_state = IDLE;
                        entry_done = 1'b1;
                    end
                    default: step_bad = 1'b1;
                endcase
            end
            EX1: begin
                unique case (b)
                    2'b01:   step_state = EX1;
                    2'b11:   step_state = EX2;
                    2'b00:   step_state = IDLE;
                    default: step_bad   = 1'b1;
                endcase
            end
            EX2: begin
                unique case (b)
                    2'b11:   step_state = EX2;
                    2'b10:   step_state = EX3;
                    2'b01:   step_state = EX1;
                    default: step_bad   = 1'b1;
                endcase
            end
            EX3: begin
                unique case (b)
                    2'b10:   step_state = EX3;
                    2'b11:   step_state = EX2;
                    2'b00: begin
                        step_state = IDLE;
                        exit_done  = 1'b1;
                    end
                    default: step_bad = 1'b1;
                endcase
            end
            default: begin
                step_state = (b == 2'b00) ? IDLE : ERR;
            end
        endcase
    end

    state_t     nxt_state;
    logic       new_err;
    logic [1:0] new_code;
    logic       do_inc;
    logic       do_dec;

    // Resolve priorities: timeout beats any transition, then sequence, then bounds.
    always_comb begin
        nxt_state = step_state;
        new_err   = 1'b0;
        new_code  = ERR_NONE;
        do_inc    = 1'b0;
        do_dec    = 1'b0;
        if (tmo_hit) begin
            nxt_state = ERR;
            new_err   = 1'b1;
            new_code  = ERR_TMO;
        end else if (step_bad) begin
            nxt_state = ERR;
            new_err   = 1'b1;
            new_code  = ERR_SEQ;
        end else if (entry_done) begin
            if (count < CAP) begin
                do_inc = 1'b1;
            end else begin
                new_err  = 1'b1;
                new_code = ERR_BOUND;
            end
        end else if (exit_done) begin
            if (count != '0) begin
                do_dec = 1'b1;
            end else begin
                new_err  = 1'b1;
                new_code = ERR_BOUND;
            end
        end
    end

    // Registered FSM state, timeout counter and all outputs.
    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= IDLE;
            tmo_cnt   <= '0;
            inc_pulse <= 1'b0;
            dec_pulse <= 1'b0;
            door_lock <= 1'b0;
            err_code  <= ERR_NONE;
            err_pulse <= 1'b0;
        end else begin
            state     <= nxt_state;
            inc_pulse <= do_inc;
            dec_pulse <= do_dec;
            door_lock <= (count >= CAP);
            err_pulse <= new_err;
            if (new_err) begin
                err_code <= new_code;
            end else if (clear_err) begin
                err_code <= ERR_NONE;
            end
            if ((nxt_state != state) || !in_pass) begin
                tmo_cnt <= '0;
            end else begin
                tmo_cnt <= tmo_cnt + 1'b1;
            end
        end
    end

    assign state_dbg = state;

endmodule

// File: tb/tb_lioncage_gate_seq.sv
// Directed bench for lioncage_gate_seq: entry/exit passes, abort, glitch,
// sequence error, timeout, capacity bounds and reset mid-pass.
module tb_lioncage_gate_seq;

    logic       clk = 1'b0;
    logic       reset;
    logic       g_one;
    logic       g_two;
    logic [3:0] count;
    logic       clear_err;
    logic       inc_pulse;
    logic       dec_pulse;
    logic       door_lock;
    logic [1:0] err_code;
    logic       err_pulse;
    logic [2:0] state_dbg;

    int n_checks = 0;
    int n_fail   = 0;
    int inc_cnt  = 0;
    int dec_cnt  = 0;
    int errp_cnt = 0;
    int both_cnt = 0;

    lioncage_gate_seq #(
        .DEBOUNCE_CYCLES(4),
        .CAPACITY       (15),
        .TIMEOUT_CYCLES (200)
    ) dut (
        .clk      (clk),
        .reset    (reset),
        .g_one    (g_one),
        .g_two    (g_two),
        .count    (count),
        .clear_err(clear_err),
        .inc_pulse(inc_pulse),
        .dec_pulse(dec_pulse),
        .door_lock(door_lock),
        .err_code (err_code),
        .err_pulse(err_pulse),
        .state_dbg(state_dbg)
    );

    always #5 clk = ~clk;

    // Pulse counters, sampled mid-cycle.
    always @(negedge clk) begin
        if (inc_pulse) inc_cnt++;
        if (dec_pulse) dec_cnt++;
        if (err_pulse) errp_cnt++;
        if (inc_pulse && dec_pulse) both_cnt++;
    end

    task automatic check(input string tag, input int obs, input int exp);
        n_checks++;
        if (obs != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic hold(input logic [1:0] bv, input int n);
        g_one = bv[1];
        g_two = bv[0];
        repeat (n) @(negedge clk);
    endtask

    task automatic zero_counts();
        inc_cnt  = 0;
        dec_cnt  = 0;
        errp_cnt = 0;
    endtask

    task automatic pulse_clear();
        clear_err = 1'b1;
        @(negedge clk);
        clear_err = 1'b0;
    endtask

    initial begin
        reset     = 1'b1;
        g_one     = 1'b0;
        g_two     = 1'b0;
        count     = 4'd3;
        clear_err = 1'b0;
        repeat (3) @(negedge clk);
        check("rst_inc", int'(inc_pulse), 0);
        check("rst_dec", int'(dec_pulse), 0);
        check("rst_lock", int'(door_lock), 0);
        check("rst_err", int'(err_code), 0);
        check("rst_errp", int'(err_pulse), 0);
        check("rst_state", int'(state_dbg), 0);
        reset = 1'b0;
        hold(2'b00, 5);

        // Full entry with count=3.
        zero_counts();
        hold(2'b10, 10);
        check("en_ph1", int'(state_dbg), 1);
        hold(2'b11, 10);
        check("en_ph2", int'(state_dbg), 2);
        hold(2'b01, 10);
        check("en_ph3", int'(state_dbg), 3);
        hold(2'b00, 10);
        check("en_inc", inc_cnt, 1);
        check("en_dec", dec_cnt, 0);
        check("en_err", int'(err_code), 0);
        check("en_state", int'(state_dbg), 0);

        // Full exit, then an aborted exit.
        zero_counts();
        hold(2'b01, 10);
        check("ex_ph1", int'(state_dbg), 4);
        hold(2'b11, 10);
        check("ex_ph2", int'(state_dbg), 5);
        hold(2'b10, 10);
        check("ex_ph3", int'(state_dbg), 6);
        hold(2'b00, 10);
        check("ex_dec", dec_cnt, 1);
        check("ex_inc", inc_cnt, 0);
        hold(2'b01, 10);
        hold(2'b00, 10);
        check("abort_dec", dec_cnt, 1);
        check("abort_state", int'(state_dbg), 0);
        check("abort_err", int'(err_code), 0);

        // Two-cycle glitch is filtered, simultaneous rise is a sequence error.
        zero_counts();
        hold(2'b10, 2);
        hold(2'b00, 10);
        check("glitch_state", int'(state_dbg), 0);
        check("glitch_errp", errp_cnt, 0);
        hold(2'b11, 10);
        check("seq_err", int'(err_code), 1);
        check("seq_state", int'(state_dbg), 7);
        check("seq_errp", errp_cnt, 1);
        hold(2'b00, 10);
        check("seq_release", int'(state_dbg), 0);
        check("seq_sticky", int'(err_code), 1);
        pulse_clear();
        check("seq_clear", int'(err_code), 0);

        // Stall in EN1 until the timeout fires.
        zero_counts();
        hold(2'b10, 100);
        check("tmo_early", int'(state_dbg), 1);
        hold(2'b10, 150);
        check("tmo_err", int'(err_code), 2);
        check("tmo_state", int'(state_dbg), 7);
        check("tmo_errp", errp_cnt, 1);
        hold(2'b00, 10);
        check("tmo_release", int'(state_dbg), 0);
        check("tmo_inc", inc_cnt, 0);
        pulse_clear();

        // Capacity bound on entry.
        zero_counts();
        count = 4'd15;
        hold(2'b00, 3);
        check("cap_lock", int'(door_lock), 1);
        hold(2'b10, 10);
        hold(2'b11, 10);
        hold(2'b01, 10);
        hold(2'b00, 10);
        check("cap_inc", inc_cnt, 0);
        check("cap_err", int'(err_code), 3);
        check("cap_errp", errp_cnt, 1);
        pulse_clear();

        // Empty-cage bound on exit.
        zero_counts();
        count = 4'd0;
        hold(2'b00, 3);
        check("empty_lock", int'(door_lock), 0);
        hold(2'b01, 10);
        hold(2'b11, 10);
        hold(2'b10, 10);
        hold(2'b00, 10);
        check("empty_dec", dec_cnt, 0);
        check("empty_err", int'(err_code), 3);
        pulse_clear();
        check("empty_clear", int'(err_code), 0);

        // Reset in the middle of an entry.
        zero_counts();
        count = 4'd3;
        hold(2'b10, 10);
        hold(2'b11, 10);
        check("mid_state", int'(state_dbg), 2);
        reset = 1'b1;
        g_one = 1'b0;
        g_two = 1'b1;
        @(negedge clk);
        check("mid_rst_state", int'(state_dbg), 0);
        check("mid_rst_err", int'(err_code), 0);
        check("mid_rst_lock", int'(door_lock), 0);
        check("mid_rst_inc", int'(inc_pulse), 0);
        reset = 1'b0;
        hold(2'b01, 10);
        hold(2'b00, 10);
        check("mid_inc", inc_cnt, 0);
        check("mid_dec", dec_cnt, 0);
        check("mid_state_end", int'(state_dbg), 0);
        check("never_both", both_cnt, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
